adder_tree_pipe: RTL and testbench

- Parametrised, pipelined signed multi-operand adder for the FFT datapath.
- Sums N_IN signed W-bit operands through a registered pairwise tree.
- Carries a valid/ready handshake with backpressure, a full-precision output and a sticky overflow flag.
- Generalises the fixed 3-input registered adder used in the butterfly twiddle/accumulate paths.

---
 rtl/adder_tree_pipe.sv | 102 ++++++++++
 tb/tb_adder_tree_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/adder_tree_pipe.sv
// Pipelined signed multi-operand adder: registered pairwise tree with valid/ready
// backpressure, full-precision output and sticky overflow. Optional macro ADDER_TREE_SAT_EN.
module adder_tree_pipe #(
  parameter int N_IN = 3,
  parameter int W    = 32,
  parameter int G    = $clog2(N_IN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_IN*W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [W-1:0]        out_data,
  output logic [W+G-1:0]      out_full,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                ovf
);

  localparam int WF  = W + G;
  localparam int LAT = ($clog2(N_IN) < 1) ? 1 : $clog2(N_IN);
  localparam int NS  = 2 * N_IN;

  // operand count present at tree level j (level 0 = sign-extended inputs)
  function automatic int lvl_cnt(input int j);
    int n;
    n = N_IN;
    for (int k = 0; k < j; k++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic logic fits_w(input logic [WF-1:0] x);
    return (&x[WF-1:W-1]) | ~(|x[WF-1:W-1]);
  endfunction

  logic [WF-1:0] st  [1:LAT][0:N_IN-1];
  logic [WF-1:0] cur [0:LAT-1][0:NS-1];
  logic [WF-1:0] nxt [1:LAT][0:N_IN-1];
  logic [LAT:1]  vld_q;
  logic [LAT:0]  vld;
  logic          en;

  assign en        = out_ready | ~out_valid;
  assign in_ready  = en;
  assign vld       = {vld_q, in_valid};
  assign out_valid = vld_q[LAT];
  assign out_full  = st[LAT][0];

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      if (i < N_IN) cur[0][i] = {{G{in_data[i*W+W-1]}}, in_data[i*W +: W]};
      else          cur[0][i] = '0;
    end
    for (int j = 1; j < LAT; j++) begin
      for (int i = 0; i < NS; i++) begin
        if (i < N_IN) cur[j][i] = st[j][i];
        else          cur[j][i] = '0;
      end
    end
    // pair adjacent operands; an odd leftover passes through unchanged
    for (int j = 1; j <= LAT; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (2*i + 1 < lvl_cnt(j-1))
          nxt[j][i] = cur[j-1][2*i] + cur[j-1][2*i+1];
        else if (2*i < lvl_cnt(j-1))
          nxt[j][i] = cur[j-1][2*i];
        else
          nxt[j][i] = '0;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      for (int j = 1; j <= LAT; j++)
        for (int i = 0; i < N_IN; i++)
          st[j][i] <= '0;
      vld_q <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      vld_q <= vld[LAT-1:0];
      // the last level only loads real results so outputs hold across bubbles
      for (int j = 1; j <= LAT; j++)
        if (j < LAT || vld[LAT-1])
          for (int i = 0; i < N_IN; i++)
            st[j][i] <= nxt[j][i];
      if (vld[LAT-1] && !fits_w(nxt[LAT][0]))
        ovf <= 1'b1;
    end
  end

`ifdef ADDER_TREE_SAT_EN
  always_comb begin
    out_data = out_full[W-1:0];
    if (!fits_w(out_full))
      out_data = out_full[WF-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
`else
  assign out_data = out_full[W-1:0];
`endif

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe (N_IN=3, W=32): vector table plus
// streaming, backpressure and reset-in-flight sequences.
module tb_adder_tree_pipe;

  logic        clk;
  logic        rst;
  logic [95:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [33:0] out_full;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  adder_tree_pipe #(.N_IN(3), .W(32)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_full(out_full), .out_valid(out_valid),
    .out_ready(out_ready), .ovf(ovf)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, c;
    logic [33:0] full;
    logic [31:0] data;
    logic        ovf;
  } vec_t;

  vec_t tbl [8];
  vec_t strm [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic stream(input int stall_start, input int stall_len);
    int          sent, got;
    logic        held_v;
    logic [31:0] held;
    sent = 0; got = 0; held_v = 0; held = '0;
    for (int t = 0; t < 40 && got < 4; t++) begin
      out_ready = !(t >= stall_start && t < stall_start + stall_len);
      in_valid  = (sent < 4);
      in_data   = (sent < 4) ? {strm[sent].c, strm[sent].b, strm[sent].a} : '0;
      #1;
      if (held_v) begin
        chk("stall_valid_hold", out_valid, 1);
        chk("stall_data_hold", out_data, held);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        chk("stream_full", out_full, strm[got].full);
        chk("stream_data", out_data, strm[got].data);
        if (stall_len == 0) chk("stream_timing", t, 2 + got);
        got++;
      end
      held_v = out_valid && !out_ready;
      held   = out_data;
      if (in_valid && in_ready) sent++;
      tick();
    end
    chk("stream_count", got, 4);
    in_valid  = 0;
    out_ready = 1;
    chk("stream_no_extra", out_valid, 0);
    tick();
    chk("stream_no_extra2", out_valid, 0);
  endtask

  initial begin
    tbl[0] = '{32'd5, 32'(-3), 32'd10, 34'd12, 32'd12, 1'b0};
    tbl[1] = '{32'd1, 32'd2, 32'd3, 34'd6, 32'd6, 1'b0};
    tbl[2] = '{32'(-7), 32'(-8), 32'(-9), 34'h3FFFFFFE8, 32'hFFFFFFE8, 1'b0};
    tbl[3] = '{32'd0, 32'd0, 32'd1, 34'd1, 32'd1, 1'b0};
    tbl[4] = '{32'h7FFFFFFE, 32'd1, 32'd0, 34'h07FFFFFFF, 32'h7FFFFFFF, 1'b0};
    tbl[5] = '{32'h80000000, 32'd0, 32'd0, 34'h380000000, 32'h80000000, 1'b0};
`ifdef ADDER_TREE_SAT_EN
    tbl[6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 34'h17FFFFFFD, 32'h7FFFFFFF, 1'b1};
`else
    tbl[6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 34'h17FFFFFFD, 32'h7FFFFFFD, 1'b1};
`endif
    tbl[7] = '{32'd100, 32'd200, 32'(-50), 34'd250, 32'd250, 1'b1};

    strm[0] = '{32'd1, 32'd2, 32'd3, 34'd6, 32'd6, 1'b0};
    strm[1] = '{32'd4, 32'd5, 32'd6, 34'd15, 32'd15, 1'b0};
    strm[2] = '{32'(-7), 32'(-8), 32'(-9), 34'h3FFFFFFE8, 32'hFFFFFFE8, 1'b0};
    strm[3] = '{32'd0, 32'd0, 32'd1, 34'd1, 32'd1, 1'b0};

    // reset with live input
    rst = 1; in_valid = 1; in_data = {32'h12345678, 32'hDEADBEEF, 32'h00C0FFEE}; out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_full", out_full, 0);
      chk("rst_ovf", ovf, 0);
    end
    rst = 0; in_valid = 0; out_ready = 0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    out_ready = 1;

    for (int v = 0; v < 8; v++) begin
      in_data  = {tbl[v].c, tbl[v].b, tbl[v].a};
      in_valid = 1;
      tick();
      chk("tbl_lat1_valid", out_valid, 0);
      in_valid = 0;
      tick();
      chk("tbl_valid", out_valid, 1);
      chk("tbl_full", out_full, tbl[v].full);
      chk("tbl_data", out_data, tbl[v].data);
      chk("tbl_ovf", ovf, tbl[v].ovf);
      tick();
      chk("tbl_bubble_valid", out_valid, 0);
      chk("tbl_bubble_hold", out_data, tbl[v].data);
    end

    stream(100, 0);
    stream(3, 3);

    // negative overflow, then reset while the next vector is in flight
    rst = 1;
    tick();
    rst = 0;
    chk("neg_pre_ovf", ovf, 0);
    in_data  = {32'h80000000, 32'h80000000, 32'h80000000};
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    chk("neg_valid", out_valid, 1);
    chk("neg_full", out_full, 34'h280000000);
    chk("neg_data", out_data, 32'h80000000);
    chk("neg_ovf", ovf, 1);
    in_data  = {32'd1, 32'd1, 32'd1};
    in_valid = 1;
    tick();
    in_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_full", out_full, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("midrst_no_deliver", out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
